// File: rtl/mcu_periph_uart.sv
// 8N1 UART on the MCU peripheral memory bus: a TX FIFO, a single-entry RX holding register,
// a programmable baud divisor and a level interrupt.
module mcu_periph_uart #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        uart_tx,
    input  logic        uart_rx,
    output logic        irq
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FullCnt = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_state_e;

    // Bus decode
    logic        mem_ready_q;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        acc, is_wr, is_rd;
    logic [1:0]  reg_sel;
    logic        data_wr, data_rd, stat_wr, baud_wr, ctrl_wr;

    assign acc     = mem_valid & ~mem_ready_q;
    assign is_wr   = acc & (|mem_wstrb);
    assign is_rd   = acc & ~(|mem_wstrb);
    assign reg_sel = mem_addr[3:2];
    assign data_wr = is_wr & (reg_sel == 2'd0) & mem_wstrb[0];
    assign data_rd = is_rd & (reg_sel == 2'd0);
    assign stat_wr = is_wr & (reg_sel == 2'd1) & mem_wstrb[0];
    assign baud_wr = is_wr & (reg_sel == 2'd2);
    assign ctrl_wr = is_wr & (reg_sel == 2'd3) & mem_wstrb[0];

    // Address and write-data bits this block does not consume
    logic unused_bits;
    assign unused_bits = ^{mem_addr[31:4], mem_addr[1:0], mem_wdata[31:16]};

    // Configuration registers
    logic [15:0] baud_q, baud_new;
    logic [1:0]  ctrl_q;

    assign baud_new = {mem_wstrb[1] ? mem_wdata[15:8] : baud_q[15:8],
                       mem_wstrb[0] ? mem_wdata[7:0]  : baud_q[7:0]};

    // BAUD and CTRL updates; a zero divisor would stall the bit counters, so store 1 instead
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_q <= DEFAULT_DIV;
            ctrl_q <= 2'b00;
        end else begin
            if (baud_wr) baud_q <= (baud_new == 16'd0) ? 16'd1 : baud_new;
            if (ctrl_wr) ctrl_q <= mem_wdata[1:0];
        end
    end

    // TX FIFO
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          tx_full, tx_empty, tx_push, tx_pop, drop_q;

    uart_state_e tx_state_q;
    logic [15:0] tx_cnt_q, tx_div_q;
    logic [7:0]  tx_shift_q;
    logic [2:0]  tx_bit_q;
    logic        tx_q, tx_busy;

    assign tx_full  = (count_q == FullCnt);
    assign tx_empty = (count_q == '0);
    assign tx_busy  = (tx_state_q != StIdle);
    assign tx_pop   = ~tx_empty & ((tx_state_q == StIdle) |
                                   ((tx_state_q == StStop) & (tx_cnt_q == 16'd0)));
    // A pop in the same cycle frees a slot, so a push while full is still accepted
    assign tx_push  = data_wr & (~tx_full | tx_pop);

    // FIFO storage needs no reset; occupancy is tracked by count_q
    always_ff @(posedge sys_clk) begin
        if (tx_push) fifo_q[wr_ptr_q] <= mem_wdata[7:0];
    end

    // FIFO pointers, occupancy and the sticky TX_DROP flag
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            if (tx_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (tx_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (tx_push & ~tx_pop)      count_q <= count_q + 1'b1;
            else if (~tx_push & tx_pop) count_q <= count_q - 1'b1;
            drop_q <= (drop_q & ~(stat_wr & mem_wdata[5])) | (data_wr & ~tx_push);
        end
    end

    // TX FSM: byte and divisor are latched on pop and held for the whole frame
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= StIdle;
            tx_cnt_q   <= '0;
            tx_div_q   <= '0;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b1;
        end else begin
            unique case (tx_state_q)
                StIdle: begin
                    if (tx_pop) begin
                        tx_state_q <= StStart;
                        tx_shift_q <= fifo_q[rd_ptr_q];
                        tx_div_q   <= baud_q;
                        tx_cnt_q   <= baud_q;
                        tx_q       <= 1'b0;
                    end
                end
                StStart: begin
                    if (tx_cnt_q == 16'd0) begin
                        tx_state_q <= StData;
                        tx_cnt_q   <= tx_div_q;
                        tx_bit_q   <= 3'd0;
                        tx_q       <= tx_shift_q[0];
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                end
                StData: begin
                    if (tx_cnt_q == 16'd0) begin
                        tx_cnt_q <= tx_div_q;
                        if (tx_bit_q == 3'd7) begin
                            tx_state_q <= StStop;
                            tx_q       <= 1'b1;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 3'd1;
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            tx_q       <= tx_shift_q[1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                end
                StStop: begin
                    if (tx_cnt_q == 16'd0) begin
                        if (tx_pop) begin
                            tx_state_q <= StStart;
                            tx_shift_q <= fifo_q[rd_ptr_q];
                            tx_div_q   <= baud_q;
                            tx_cnt_q   <= baud_q;
                            tx_q       <= 1'b0;
                        end else begin
                            tx_state_q <= StIdle;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                end
                default: tx_state_q <= StIdle;
            endcase
        end
    end

    // RX path
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    uart_state_e rx_state_q;
    logic [15:0] rx_cnt_q, rx_div_q, rx_half_m1;
    logic [7:0]  rx_shift_q, rx_byte_q;
    logic [2:0]  rx_bit_q;
    logic        rx_valid_q, rx_ovr_q, rx_ferr_q;

    // floor((BAUD_DIV+1)/2) - 1; BAUD_DIV is never 0
    assign rx_half_m1 = {1'b0, baud_q[15:1]} + {15'd0, baud_q[0]} - 16'd1;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= uart_rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    // RX FSM with holding register and error flags; hardware set wins over a W1C clear
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= StIdle;
            rx_cnt_q   <= '0;
            rx_div_q   <= '0;
            rx_shift_q <= '0;
            rx_bit_q   <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            if (data_rd)                 rx_valid_q <= 1'b0;
            if (stat_wr & mem_wdata[4])  rx_ovr_q   <= 1'b0;
            if (stat_wr & mem_wdata[6])  rx_ferr_q  <= 1'b0;
            unique case (rx_state_q)
                StIdle: begin
                    if (rx_prev_q & ~rx_s2_q) begin
                        rx_state_q <= StStart;
                        rx_div_q   <= baud_q;
                        rx_cnt_q   <= rx_half_m1;
                    end
                end
                StStart: begin
                    if (rx_cnt_q == 16'd0) begin
                        if (rx_s2_q) begin
                            rx_state_q <= StIdle;
                        end else begin
                            rx_state_q <= StData;
                            rx_cnt_q   <= rx_div_q;
                            rx_bit_q   <= 3'd0;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                StData: begin
                    if (rx_cnt_q == 16'd0) begin
                        rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                        rx_cnt_q   <= rx_div_q;
                        if (rx_bit_q == 3'd7) rx_state_q <= StStop;
                        else                  rx_bit_q   <= rx_bit_q + 3'd1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                StStop: begin
                    if (rx_cnt_q == 16'd0) begin
                        rx_state_q <= StIdle;
                        if (!rx_s2_q) begin
                            rx_ferr_q <= 1'b1;
                        end else if (data_rd || !rx_valid_q) begin
                            rx_byte_q  <= rx_shift_q;
                            rx_valid_q <= 1'b1;
                        end else begin
                            rx_ovr_q <= 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                default: rx_state_q <= StIdle;
            endcase
        end
    end

    // Read data mux
    always_comb begin
        mem_rdata_d = '0;
        unique case (reg_sel)
            2'd0: mem_rdata_d = {24'h0, rx_byte_q};
            2'd1: mem_rdata_d = {25'h0, rx_ferr_q, drop_q, rx_ovr_q, rx_valid_q,
                                 tx_busy, tx_empty, tx_full};
            2'd2: mem_rdata_d = {16'h0, baud_q};
            2'd3: mem_rdata_d = {30'h0, ctrl_q};
            default: mem_rdata_d = '0;
        endcase
    end

    // Bus response and registered interrupt
    logic irq_q;
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ready_q <= 1'b0;
            mem_rdata_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            mem_ready_q <= acc;
            mem_rdata_q <= is_rd ? mem_rdata_d : 32'h0;
            irq_q       <= (rx_valid_q & ctrl_q[0]) | (tx_empty & ~tx_busy & ctrl_q[1]);
        end
    end

    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;
    assign uart_tx   = tx_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_mcu_periph_uart.sv
// Self-checking bench for mcu_periph_uart: register vector table, TX scoreboard, RX frames.
module tb_mcu_periph_uart;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        uart_tx;
    logic        uart_rx;
    logic        irq;

    int checks   = 0;
    int failures = 0;
    logic [7:0] tx_sb [$];
    bit mon_en = 1'b0;

    always #5 sys_clk = ~sys_clk;

    mcu_periph_uart #(
        .FIFO_DEPTH (8),
        .DEFAULT_DIV(16'd433)
    ) dut (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .mem_valid(mem_valid),
        .mem_ready(mem_ready),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata),
        .uart_tx  (uart_tx),
        .uart_rx  (uart_rx),
        .irq      (irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One bus access; called and returns at posedge+1
    task automatic bus(input logic [3:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                       output logic [31:0] rd);
        mem_valid = 1'b1;
        mem_addr  = {28'h0, addr};
        mem_wdata = wd;
        mem_wstrb = ws;
        @(posedge sys_clk); #1;
        chk("ready_latency", mem_ready, 1'b1);
        rd = mem_rdata;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        @(posedge sys_clk); #1;
        chk("ready_pulse", mem_ready, 1'b0);
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] wd, input logic [3:0] ws);
        logic [31:0] r;
        bus(addr, wd, ws, r);
        chk("write_rdata_zero", r, 32'h0);
    endtask

    task automatic rd_chk(input string name, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] r;
        bus(addr, 32'h0, 4'h0, r);
        chk(name, r, exp);
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (tx_sb.size() != 0 && n < max) begin
            @(posedge sys_clk); #1;
            n++;
        end
        chk("tx_drain", tx_sb.size(), 0);
        repeat (4) @(posedge sys_clk);
        #1;
    endtask

    // Drive an 8N1 frame at 8 cycles per bit (BAUD=7), then 4 idle cycles
    task automatic send_rx(input logic [7:0] d, input logic stop);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = fr[i];
            repeat (8) @(posedge sys_clk);
            #1;
        end
        uart_rx = 1'b1;
        repeat (4) @(posedge sys_clk);
        #1;
    endtask

    // TX monitor: decodes frames at 4 cycles per bit (BAUD=3) and checks them against tx_sb
    initial begin
        logic [7:0] b;
        forever begin
            @(posedge sys_clk); #1;
            if (mon_en && rst_n && uart_tx === 1'b0) begin
                repeat (2) @(posedge sys_clk);
                #1;
                chk("tx_start_bit", uart_tx, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(posedge sys_clk);
                    #1;
                    b[i] = uart_tx;
                end
                repeat (4) @(posedge sys_clk);
                #1;
                chk("tx_stop_bit", uart_tx, 1'b1);
                if (tx_sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected: got 0x%0h expected no frame", b);
                end else begin
                    chk("tx_byte", b, tx_sb.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [15];

    initial begin
        logic [31:0] r;
        logic [9:0]  fr;
        int n;
        int errs;

        vecs[0]  = '{4'h0, 32'h0,        4'h0, 32'h0,    1'b0};
        vecs[1]  = '{4'h4, 32'h0,        4'h0, 32'h2,    1'b0};
        vecs[2]  = '{4'h8, 32'h0,        4'h0, 32'h1B1,  1'b0};
        vecs[3]  = '{4'hC, 32'h0,        4'h0, 32'h0,    1'b0};
        vecs[4]  = '{4'h8, 32'h0,        4'h3, 32'h0,    1'b0};
        vecs[5]  = '{4'h8, 32'h0,        4'h0, 32'h1,    1'b0};
        vecs[6]  = '{4'h8, 32'h1234ABCD, 4'h2, 32'h0,    1'b0};
        vecs[7]  = '{4'h8, 32'h0,        4'h0, 32'hAB01, 1'b0};
        vecs[8]  = '{4'hC, 32'hFFFFFFFF, 4'hF, 32'h0,    1'b1};
        vecs[9]  = '{4'hC, 32'h0,        4'h0, 32'h3,    1'b1};
        vecs[10] = '{4'hC, 32'h0,        4'h1, 32'h0,    1'b0};
        vecs[11] = '{4'h4, 32'hFFFFFFFF, 4'h1, 32'h0,    1'b0};
        vecs[12] = '{4'h4, 32'h0,        4'h0, 32'h2,    1'b0};
        vecs[13] = '{4'h8, 32'h3,        4'h3, 32'h0,    1'b0};
        vecs[14] = '{4'h8, 32'h0,        4'h0, 32'h3,    1'b0};

        rst_n     = 1'b0;
        uart_rx   = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_ready", mem_ready, 1'b0);
        chk("rst_rdata", mem_rdata, 32'h0);
        chk("rst_tx", uart_tx, 1'b1);
        chk("rst_irq", irq, 1'b0);
        rst_n = 1'b1;
        @(posedge sys_clk); #1;

        // Register map vectors
        for (int i = 0; i < 15; i++) begin
            bus(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, r);
            chk($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_irq", i), irq, vecs[i].exp_irq);
        end

        // Single frame 0xA5 at BAUD=3: exact waveform and TX-empty irq timing
        mon_en = 1'b1;
        wr(4'hC, 32'h2, 4'h1);
        chk("txe_irq_idle", irq, 1'b1);
        tx_sb.push_back(8'hA5);
        wr(4'h0, 32'hA5, 4'h1);
        n = 0;
        while (uart_tx !== 1'b0 && n < 10) begin
            @(posedge sys_clk); #1;
            n++;
        end
        chk("tx_start_seen", uart_tx, 1'b0);
        fr   = {1'b1, 8'hA5, 1'b0};
        errs = 0;
        for (n = 0; n < 200 && irq !== 1'b1; n++) begin
            if (n < 40 && uart_tx !== fr[n/4]) errs++;
            @(posedge sys_clk); #1;
        end
        chk("tx_wave_errs", errs, 0);
        chk("txe_irq_delay", n, 41);
        wr(4'hC, 32'h0, 4'h1);
        drain(200);

        // Nine back-to-back pushes, then a dropped tenth
        for (int k = 0; k < 9; k++) begin
            tx_sb.push_back(8'h30 + 8'(k));
            wr(4'h0, 32'h30 + k, 4'h1);
        end
        rd_chk("status_full", 4'h4, 32'h05);
        wr(4'h0, 32'hEE, 4'h1);
        rd_chk("status_drop", 4'h4, 32'h25);
        wr(4'h4, 32'h20, 4'h1);
        rd_chk("status_drop_clr", 4'h4, 32'h05);
        drain(1000);
        rd_chk("status_tx_idle", 4'h4, 32'h02);
        mon_en = 1'b0;

        // RX at BAUD=7 with RX interrupt enabled
        wr(4'h8, 32'h7, 4'h3);
        wr(4'hC, 32'h1, 4'h1);
        send_rx(8'h3C, 1'b1);
        n = 0;
        while (irq !== 1'b1 && n < 40) begin
            @(posedge sys_clk); #1;
            n++;
        end
        chk("rx_irq_rise", irq, 1'b1);
        rd_chk("rx_status_valid", 4'h4, 32'h0A);
        rd_chk("rx_data", 4'h0, 32'h3C);
        chk("rx_irq_fall", irq, 1'b0);
        rd_chk("rx_status_clr", 4'h4, 32'h02);

        // Overrun keeps the first byte
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        repeat (20) @(posedge sys_clk);
        #1;
        rd_chk("rx_status_ovr", 4'h4, 32'h1A);
        rd_chk("rx_data_first", 4'h0, 32'h11);

        // Framing error discards the byte
        send_rx(8'h55, 1'b0);
        repeat (20) @(posedge sys_clk);
        #1;
        rd_chk("rx_status_ferr", 4'h4, 32'h52);
        wr(4'h4, 32'h50, 4'h1);
        rd_chk("rx_status_w1c", 4'h4, 32'h02);

        // Two-cycle glitch is rejected
        uart_rx = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        uart_rx = 1'b1;
        repeat (100) @(posedge sys_clk);
        #1;
        rd_chk("rx_glitch_status", 4'h4, 32'h02);
        rd_chk("rx_glitch_data", 4'h0, 32'h11);
        chk("rx_glitch_irq", irq, 1'b0);

        // Reset in the middle of a frame
        wr(4'h0, 32'h00, 4'h1);
        wr(4'h0, 32'h00, 4'h1);
        repeat (10) @(posedge sys_clk);
        #1;
        chk("tx_mid_low", uart_tx, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", uart_tx, 1'b1);
        chk("rst_mid_ready", mem_ready, 1'b0);
        @(posedge sys_clk); #1;
        rst_n = 1'b1;
        @(posedge sys_clk); #1;
        rd_chk("rst_mid_status", 4'h4, 32'h02);
        rd_chk("rst_mid_baud", 4'h8, 32'h1B1);
        repeat (20) @(posedge sys_clk);
        #1;
        chk("rst_mid_tx_idle", uart_tx, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
